// File: rtl/decade_count_pkg.sv
// Shared encodings for the decade counter controller: command opcodes,
// controller states and BCD digit constants.
package decade_count_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_NINE = 4'd9;

  typedef enum logic [1:0] {
    OP_START = 2'b00,
    OP_STOP  = 2'b01,
    OP_CLEAR = 2'b10,
    OP_LOAD  = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/decade_count_ctrl_bcd_digit.sv
// One mod-10 BCD digit. Carry-out is asserted when this digit is enabled
// while holding 9, i.e. exactly when it rolls over to 0.
module bcd_digit
  import decade_count_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               clr,
  output logic [DIGIT_W-1:0] q,
  output logic               carry
);

  assign carry = en && (q == DIGIT_NINE);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (en) begin
      q <= carry ? '0 : q + 1'b1;
    end
  end

endmodule

// File: rtl/decade_count_ctrl.sv
// Command-driven controller for a cascade of BCD digits: start/stop/clear/
// load over valid/ready, counts qualified ticks, flags target match and wrap.
module decade_count_ctrl
  import decade_count_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  input  logic [1:0]                cmd_op,
  input  logic [DIGIT_W*DIGITS-1:0] cmd_data,
  output logic                      cmd_ready,
  input  logic                      tick,
  output logic [DIGIT_W*DIGITS-1:0] q,
  output logic                      busy,
  output logic                      done,
  output logic                      wrap
);

  localparam int QW = DIGIT_W * DIGITS;

  state_e          state;
  logic [QW-1:0]   target;
  logic [QW-1:0]   next_q;
  logic [DIGITS:0] chain;
  logic            accept;
  logic            inc;
  logic            clr_cnt;

  function automatic logic [QW-1:0] sat_bcd(input logic [QW-1:0] d);
    logic [QW-1:0] r;
    r = d;
    for (int i = 0; i < DIGITS; i++) begin
      if (d[DIGIT_W*i +: DIGIT_W] > DIGIT_NINE) r[DIGIT_W*i +: DIGIT_W] = DIGIT_NINE;
    end
    return r;
  endfunction

  function automatic logic [DIGIT_W-1:0] digit_step(input logic [DIGIT_W-1:0] d,
                                                    input logic en);
    if (!en) return d;
    return (d == DIGIT_NINE) ? '0 : d + 1'b1;
  endfunction

  // START/LOAD stall while running so the count cannot be disturbed mid-run.
  assign cmd_ready = (state != ST_RUN) || (cmd_op == OP_STOP) || (cmd_op == OP_CLEAR);
  assign accept    = cmd_valid && cmd_ready;
  assign inc       = (state == ST_RUN) && tick && !accept;
  assign clr_cnt   = accept && ((cmd_op == OP_CLEAR) ||
                                ((cmd_op == OP_START) && (state == ST_DONE)));
  assign chain[0]  = inc;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .reset (reset),
      .en    (chain[g]),
      .clr   (clr_cnt),
      .q     (q[DIGIT_W*g +: DIGIT_W]),
      .carry (chain[g+1])
    );
  end

  // Value the digits will hold after this edge, used for the target compare.
  always_comb begin
    next_q = q;
    for (int i = 0; i < DIGITS; i++) begin
      next_q[DIGIT_W*i +: DIGIT_W] = digit_step(q[DIGIT_W*i +: DIGIT_W], chain[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      target <= {DIGITS{DIGIT_NINE}};
      busy   <= 1'b0;
      done   <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      if (accept) begin
        case (cmd_op)
          OP_START: begin
            state <= ST_RUN;
            busy  <= 1'b1;
          end
          OP_STOP: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          OP_CLEAR: begin
            if (state == ST_DONE) state <= ST_IDLE;
          end
          default: target <= sat_bcd(cmd_data);
        endcase
      end else if (inc) begin
        wrap <= chain[DIGITS];
        if (next_q == target) begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/decade_count_ctrl.md
# decade_count_ctrl

Command-driven controller that sequences a chain of mod-10 (BCD) digit counters as a programmable decimal event counter. Accepts start/stop/clear/load commands over a valid/ready handshake, advances the cascaded digits on each qualified `tick`, and flags arrival at a loaded BCD target and full-scale wrap. Sits between a host/sequencer and the decade-counter datapath, so the counter digits only move under controller authority.

## Interface
- `DIGITS`, 3, number of cascaded BCD digits (1..8); digit 0 is least significant
- `clk`  in  1  single clock, all logic rising-edge
- `reset`  in  1  synchronous, active-high
- `cmd_valid`  in  1  command present
- `cmd_op`  in  2  00 START, 01 STOP, 10 CLEAR, 11 LOAD
- `cmd_data`  in  4*DIGITS  BCD target, used by LOAD only
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`
- `tick`  in  1  count-enable pulse, one increment per high cycle while RUN
- `q`  out  4*DIGITS  current BCD count, digit i at bits 4i+3:4i
- `busy`  out  1  registered, high iff state RUN
- `done`  out  1  one-cycle pulse, count reached target
- `wrap`  out  1  one-cycle pulse, count rolled all-9s to 0

## Operation
- States: IDLE, RUN, DONE. Reset: state IDLE, `q`=0, target=all 9s, `busy`/`done`/`wrap`=0.
- `cmd_ready` combinational: 1 in IDLE and DONE; in RUN 1 only for STOP and CLEAR, 0 for START/LOAD (command stalls until state leaves RUN).
- START: IDLE->RUN, count retained. DONE->RUN with count cleared to 0.
- STOP: RUN->IDLE, count held. DONE->IDLE, count held. IDLE: no effect.
- CLEAR: count := 0 in any state; RUN stays RUN; DONE->IDLE; IDLE stays.
- LOAD: target := `cmd_data`; any digit > 9 saturates to 9. State and count unchanged.
- Increment (RUN, `tick`=1, no accepted command): BCD add 1; digit i increments only when digits 0..i-1 are all 9; digit 9 -> 0 with carry. Never produces a digit > 9.
- All 9s + tick -> all 0s, `wrap` pulses; state stays RUN unless target is 0.
- If incremented value equals target: state -> DONE, `done` pulses. Match tested only on the new value, never on the held value (START with count already equal to target runs a full cycle).
- DONE: ticks ignored, count frozen at target.
- Accepted command and `tick` in same cycle: command wins, tick dropped.
- Reset asserted mid-operation: all state returns to reset values next edge; pending command and tick discarded.

## Timing
- Accepted command takes effect at the next edge; `q`, `busy` reflect it the following cycle.
- `tick` sampled at edge N -> new `q` visible after edge N; `done`/`wrap` registered and high in the same cycle as the matching `q`, low the next cycle.
- `busy` falls in the same cycle `done` rises.
- No combinational path from `tick` to any output; `cmd_ready` depends only on state and `cmd_op`.

## Structure
- Package `decade_count_pkg`: `cmd_op` encodings, state enum, BCD digit width constant (4), all-9s digit constant.
- Sub-module `bcd_digit`: one mod-10 digit with enable in, clear in, carry-out (= enable && digit==9); instantiated DIGITS times in a generate loop, carry chained.
- Target register, saturation logic, compare and FSM stay in the top.

## Test plan
- DIGITS=2, reset, LOAD 0x12, START, 12 ticks -> `q`=0x12, `done` pulse on 12th, `busy`=0, 3 more ticks leave `q`=0x12.
- Default target 0x99, START, 100 ticks -> `q` steps 0x09->0x10 correctly, 0x99 asserts `done`; START again clears to 0x00 and resumes.
- LOAD 0x00, START from `q`=0x00, 100 ticks -> `wrap` and `done` both pulse on cycle q returns to 0x00.
- LOAD 0xAF -> stored target 0x99; LOAD while RUN -> `cmd_ready`=0 until STOP accepted, then LOAD completes.
- RUN at `q`=0x37, CLEAR with `tick`=1 same cycle -> `q`=0x00, still RUN; STOP with tick -> `q` held, IDLE.
- Reset asserted at `q`=0x45 in RUN with `cmd_valid` -> next cycle `q`=0x00, IDLE, target 0x99, all flags 0.
